// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: datapath widths, fetch FSM encoding,
// queue entry layout and the instruction encodings decode also relies on.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_KILL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  // RV32-style opcode/funct fields; li is addi with rs1 = x0.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LI     = OPC_OP_IMM;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  function automatic logic isBne(input logic [INSTR_W-1:0] instr);
    return (instr[6:0] == OPC_BRANCH) && (instr[14:12] == F3_BNE);
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, decode delivery,
// branch redirect and queue occupancy. master = fetch unit, slave = environment.
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               available;
  logic               decodePulse;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [CNT_W-1:0]   queue_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    input  available,
    output decodePulse, instr_out, pc_out,
    input  redirect_valid, redirect_pc,
    output queue_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    output available,
    input  decodePulse, instr_out, pc_out,
    output redirect_valid, redirect_pc,
    input  queue_count
  );

endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, instr} entries with push/pop/flush; the occupancy
// counter is what tells full from empty once the pointers have wrapped.
module ifq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  ifq_entry_t       i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output ifq_entry_t       o_rdata,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != FULL_COUNT) || w_doPop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_tail <= r_tail + PTR_W'(1);
      if (w_doPop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush && !i_flush) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: sequential PC generation, single-outstanding imem requests,
// queued delivery to decode and redirect flush. Optional IFQ_BYPASS_EN.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic                       clock,
  input logic                       reset,
  instruction_fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic               r_imem_req;
  logic [PC_W-1:0]    r_imem_addr;
  logic               r_decodePulse;
  logic [INSTR_W-1:0] r_instr_out;
  logic [PC_W-1:0]    r_pc_out;

  logic [CNT_W-1:0]   w_count;
  ifq_entry_t         w_head;
  ifq_entry_t         w_wdata;
  logic               w_redirect;
  logic               w_empty;
  logic               w_respAccept;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;

  assign w_redirect   = bus.redirect_valid;
  assign w_empty      = (w_count == '0);
  assign w_respAccept = (r_state == FS_WAIT) && bus.imem_valid && !w_redirect;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_respAccept && w_empty && bus.available;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push  = w_respAccept && !w_bypass;
  assign w_pop   = !w_empty && bus.available && !w_redirect;
  assign w_wdata = '{pc: r_pc, instr: bus.imem_rdata};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // Requests only leave FETCH while a slot is free, so the single in-flight
  // response always has room; KILL swallows a response made stale by redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= FS_FETCH;
      r_pc        <= PC_INIT;
      r_imem_req  <= 1'b0;
      r_imem_addr <= PC_INIT;
    end else begin
      r_imem_req <= 1'b0;
      if (w_redirect) begin
        r_pc <= bus.redirect_pc;
        if ((r_state == FS_WAIT || r_state == FS_KILL) && !bus.imem_valid) r_state <= FS_KILL;
        else                                                                r_state <= FS_FETCH;
      end else begin
        case (r_state)
          FS_FETCH: begin
            if (w_count < FULL_COUNT) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc;
              r_state     <= FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (bus.imem_valid) begin
              r_pc    <= r_pc + PC_STEP;
              r_state <= FS_FETCH;
            end
          end
          FS_KILL: begin
            if (bus.imem_valid) r_state <= FS_FETCH;
          end
          default: r_state <= FS_FETCH;
        endcase
      end
    end
  end

  // Registered delivery to decode; a redirect cancels any issue that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_decodePulse <= 1'b0;
      r_instr_out   <= '0;
      r_pc_out      <= '0;
    end else if (w_redirect) begin
      r_decodePulse <= 1'b0;
    end else if (w_bypass) begin
      r_decodePulse <= 1'b1;
      r_instr_out   <= bus.imem_rdata;
      r_pc_out      <= r_pc;
    end else if (w_pop) begin
      r_decodePulse <= 1'b1;
      r_instr_out   <= w_head.instr;
      r_pc_out      <= w_head.pc;
    end else begin
      r_decodePulse <= 1'b0;
    end
  end

  // A response with nothing outstanding breaks the memory protocol.
  assert property (@(posedge clock) disable iff (reset)
    !((r_state == FS_FETCH) && bus.imem_valid));

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.decodePulse = r_decodePulse;
  assign bus.instr_out   = r_instr_out;
  assign bus.pc_out      = r_pc_out;
  assign bus.queue_count = w_count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: in-order fetch/issue, stall and
// drain, redirect handling, pointer/PC wrap and asynchronous reset mid-request.
module tb_instruction_fetch_queue;

  logic clock;
  logic reset;

  instruction_fetch_queue_if #(.DEPTH(4)) bus ();

  instruction_fetch_queue #(
    .DEPTH   (4),
    .PC_INIT (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int memDelay    = 1;
  int respCnt     = 0;
  logic [31:0] respAddr = '0;
  int maxCount    = 0;

  logic [31:0] issuedPc[$];
  logic [31:0] issuedInstr[$];
  logic [31:0] reqAddr[$];

  int pcBase;
  int reqBase;
  logic sawLate;

  // Clock: 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory: answers memDelay cycles after each observed request.
  initial begin : responder
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.imem_valid = 1'b0;
      if (respCnt > 0) begin
        respCnt--;
        if (respCnt == 0) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = memWord(respAddr);
        end
      end
      if (bus.imem_req === 1'b1 && !reset) begin
        respAddr = bus.imem_addr;
        respCnt  = memDelay;
      end
    end
  end

  // Log every request and every delivered instruction.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.decodePulse === 1'b1) begin
        issuedPc.push_back(bus.pc_out);
        issuedInstr.push_back(bus.instr_out);
      end
      if (bus.imem_req === 1'b1) reqAddr.push_back(bus.imem_addr);
      if (int'(bus.queue_count) > maxCount) maxCount = int'(bus.queue_count);
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, required $finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic avail, input logic redir, input logic [31:0] rpc);
    bus.available      = avail;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    @(posedge clock);
    #2;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_imem_req"},    32'(bus.imem_req),    32'd0);
    checkOutput({tag, "_imem_addr"},   bus.imem_addr,        32'h0000_0000);
    checkOutput({tag, "_decodePulse"}, 32'(bus.decodePulse), 32'd0);
    checkOutput({tag, "_instr_out"},   bus.instr_out,        32'd0);
    checkOutput({tag, "_pc_out"},      bus.pc_out,           32'd0);
    checkOutput({tag, "_queue_count"}, 32'(bus.queue_count), 32'd0);
  endtask

  initial begin : stimulus
    reset              = 1'b1;
    bus.available      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    memDelay           = 1;
    repeat (2) @(posedge clock);
    #2;

    $display("[TB] reset values");
    checkResetOutputs("rst");

    $display("[TB] sequential fetch with 1-cycle memory");
    bus.available = 1'b1;
    reset   = 1'b0;
    pcBase  = issuedPc.size();
    reqBase = reqAddr.size();
    for (int i = 0; i < 50 && bus.imem_valid !== 1'b1; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_first_valid", 32'(bus.imem_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_pulse_after_1", 32'(bus.decodePulse), 32'(LAT == 1));
    for (int i = 1; i < LAT; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_first_pulse", 32'(bus.decodePulse), 32'd1);
    checkOutput("t1_first_pc",    bus.pc_out,            32'h0);
    checkOutput("t1_first_instr", bus.instr_out,         memWord(32'h0));
    for (int i = 0; i < 200 && issuedPc.size() < pcBase + 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_issued_4", 32'(issuedPc.size() >= pcBase + 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t1_req_addr%0d", k),  reqAddr[reqBase + k],    32'(4 * k));
      checkOutput($sformatf("t1_issue_pc%0d", k),  issuedPc[pcBase + k],    32'(4 * k));
      checkOutput($sformatf("t1_issue_ins%0d", k), issuedInstr[pcBase + k], memWord(32'(4 * k)));
    end

    $display("[TB] stall until full, then drain");
    applyStimulus(1'b0, 1'b1, 32'h0000_0000);
    pcBase  = issuedPc.size();
    reqBase = reqAddr.size();
    checkOutput("t2_redir_pulse", 32'(bus.decodePulse), 32'd0);
    checkOutput("t2_redir_count", 32'(bus.queue_count), 32'd0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t2_full_count", 32'(bus.queue_count),          32'd4);
    checkOutput("t2_req_total",  32'(reqAddr.size() - reqBase), 32'd4);
    checkOutput("t2_no_5th_req", 32'(bus.imem_req),             32'd0);
    checkOutput("t2_no_issue",   32'(issuedPc.size() - pcBase), 32'd0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t2_req_addr%0d", k), reqAddr[reqBase + k], 32'(4 * k));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput($sformatf("t2_drain_pulse%0d", k), 32'(bus.decodePulse), 32'd1);
      checkOutput($sformatf("t2_drain_pc%0d", k),    bus.pc_out,            32'(4 * k));
      checkOutput($sformatf("t2_drain_ins%0d", k),   bus.instr_out,         memWord(32'(4 * k)));
    end
    for (int i = 0; i < 20 && reqAddr.size() < reqBase + 5; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t2_resume_addr", reqAddr[reqBase + 4], 32'h10);

    $display("[TB] redirect while waiting on a slow response");
    memDelay = 3;
    for (int i = 0; i < 30 && bus.imem_req !== 1'b1; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_req_seen", 32'(bus.imem_req), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h40);
    pcBase  = issuedPc.size();
    reqBase = reqAddr.size();
    checkOutput("t3_count",  32'(bus.queue_count), 32'd0);
    checkOutput("t3_pulse",  32'(bus.decodePulse), 32'd0);
    for (int i = 0; i < 60 && issuedPc.size() < pcBase + 2; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_next_req",  reqAddr[reqBase],      32'h40);
    checkOutput("t3_first_pc",  issuedPc[pcBase],      32'h40);
    checkOutput("t3_first_ins", issuedInstr[pcBase],   memWord(32'h40));
    checkOutput("t3_second_pc", issuedPc[pcBase + 1],  32'h44);

    $display("[TB] redirect coincident with response and pending issue");
    memDelay = 1;
    for (int i = 0; i < 40 && !(bus.imem_valid === 1'b1 && bus.queue_count != '0); i++)
      applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t4_setup", 32'(bus.imem_valid === 1'b1 && bus.queue_count != '0), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h80);
    pcBase = issuedPc.size();
    checkOutput("t4_pulse", 32'(bus.decodePulse), 32'd0);
    checkOutput("t4_count", 32'(bus.queue_count), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_req",  32'(bus.imem_req), 32'd1);
    checkOutput("t4_addr", bus.imem_addr,     32'h80);
    for (int i = 0; i < 20 && issuedPc.size() < pcBase + 1; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_first_pc", issuedPc[pcBase], 32'h80);

    $display("[TB] pointer and PC wrap with interleaved stalls");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0);
    pcBase  = issuedPc.size();
    reqBase = reqAddr.size();
    for (int i = 0; i < 300 && issuedPc.size() < pcBase + 10; i++)
      applyStimulus(logic'((i % 9) >= 5), 1'b0, 32'd0);
    checkOutput("t5_issued_10", 32'(issuedPc.size() >= pcBase + 10), 32'd1);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t5_pc%0d", k),  issuedPc[pcBase + k],    32'hFFFF_FFF0 + 32'(4 * k));
      checkOutput($sformatf("t5_ins%0d", k), issuedInstr[pcBase + k], memWord(32'hFFFF_FFF0 + 32'(4 * k)));
    end
    checkOutput("t5_req_fffc",   reqAddr[reqBase + 3], 32'hFFFF_FFFC);
    checkOutput("t5_req_wrap",   reqAddr[reqBase + 4], 32'h0000_0000);
    checkOutput("t5_max_count",  32'(maxCount <= 4),   32'd1);

    $display("[TB] asynchronous reset mid-request");
    memDelay = 3;
    for (int i = 0; i < 30 && bus.imem_req !== 1'b1; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t6_req_seen", 32'(bus.imem_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    sawLate = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #2;
      if (bus.imem_valid === 1'b1) sawLate = 1'b1;
    end
    checkOutput("t6_late_valid_seen", 32'(sawLate), 32'd1);
    checkOutput("t6_hold_count", 32'(bus.queue_count), 32'd0);
    checkOutput("t6_hold_pulse", 32'(bus.decodePulse), 32'd0);
    memDelay = 1;
    pcBase   = issuedPc.size();
    reqBase  = reqAddr.size();
    reset    = 1'b0;
    for (int i = 0; i < 30 && issuedPc.size() < pcBase + 1; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t6_restart_req", reqAddr[reqBase],    32'h0);
    checkOutput("t6_restart_pc",  issuedPc[pcBase],    32'h0);
    checkOutput("t6_restart_ins", issuedInstr[pcBase], memWord(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
